router_fifo_pkt: RTL and testbench

Parametrised, packet-aware output FIFO for the router's per-destination channels; successor to the fixed 16x8 channel FIFO. Stores bytes tagged with a header flag, tracks packet boundaries on read, and reports fill level and almost-full to the router FSM. Adds a built-in read-timeout flush, so the FIFO drains itself when the destination stops reading.

---
 rtl/router_fifo_pkt.sv | 148 ++++++++++++++
 tb/tb_router_fifo_pkt.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/router_fifo_pkt.sv
// router_fifo_pkt
// Packet-aware output FIFO for one router destination channel. Each entry
// stores a data byte plus a header flag. On read, the FIFO follows packet
// boundaries: a header byte carries the payload length in data[DATA_WIDTH-1:2],
// and pkt_done marks the trailing parity byte. The FIFO reports its fill level
// and almost-full to the router FSM. If the destination stops reading, the FIFO
// flushes itself.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous active-high full clear
//   soft_reset     synchronous active-high flush (protocol_err is kept)
//   write_enb      write request; lfd_state flags data_in as a header byte
//   data_in        write data
//   read_enb       read request
//   data_out       registered read data (1-cycle latency)
//   data_out_valid data_out was popped on the previous edge
//   pkt_done       pulse alongside the last (parity) byte of a packet
//   full/empty/almost_full  decoded from the registered fill_level
//   fill_level     number of stored entries
//   timeout_flush  pulse on the edge where an idle auto-flush happened
//   protocol_err   sticky: payload byte popped while no packet was open
module router_fifo_pkt #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = 14,
  parameter int TIMEOUT     = 30
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    soft_reset,
  input  logic                    write_enb,
  input  logic                    lfd_state,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    read_enb,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    data_out_valid,
  output logic                    pkt_done,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic [$clog2(DEPTH):0]  fill_level,
  output logic                    timeout_flush,
  output logic                    protocol_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int IW = $clog2(TIMEOUT);
  localparam int RW = DATA_WIDTH - 1;

  // Remaining bytes of a packet once its header is popped: payload + parity.
  function automatic logic [RW-1:0] hdr_rem(input logic [DATA_WIDTH-1:0] hdr);
    return RW'(hdr[DATA_WIDTH-1:2]) + RW'(1);
  endfunction

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [RW-1:0]       pkt_rem;
  logic [IW-1:0]       idle_cnt;

  logic                wr_acc;
  logic                rd_acc;
  logic                idle;
  logic                flush_now;
  logic                clear_all;
  logic [DATA_WIDTH:0] pop_entry;
  logic                pop_hdr;
  logic [DATA_WIDTH-1:0] pop_byte;

  assign full        = (fill_level == FW'(DEPTH));
  assign empty       = (fill_level == '0);
  assign almost_full = (fill_level >= FW'(AFULL_LEVEL));

  assign wr_acc    = write_enb && !full;
  assign rd_acc    = read_enb && !empty;
  assign idle      = !empty && !rd_acc;
  // The counter already holds TIMEOUT-1 idle cycles; this idle cycle is the last one.
  assign flush_now = idle && (idle_cnt == IW'(TIMEOUT - 1));
  assign clear_all = reset || soft_reset || flush_now;

  assign pop_entry = mem[rd_ptr];
  assign pop_hdr   = pop_entry[DATA_WIDTH];
  assign pop_byte  = pop_entry[DATA_WIDTH-1:0];

  // Storage: a write coinciding with any kind of clear is discarded.
  always_ff @(posedge clk) begin
    if (wr_acc && !clear_all) begin
      mem[wr_ptr] <= {lfd_state, data_in};
    end
  end

  // Pointers, level, packet tracking, idle timer, output register
  always_ff @(posedge clk) begin
    if (reset || soft_reset || flush_now) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fill_level     <= '0;
      pkt_rem        <= '0;
      idle_cnt       <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      pkt_done       <= 1'b0;
      // A soft reset takes precedence, so only a genuine auto-flush pulses.
      timeout_flush  <= !reset && !soft_reset;
      if (reset) begin
        protocol_err <= 1'b0;
      end
    end else begin
      timeout_flush <= 1'b0;

      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end

      unique case ({wr_acc, rd_acc})
        2'b10:   fill_level <= fill_level + FW'(1);
        2'b01:   fill_level <= fill_level - FW'(1);
        default: fill_level <= fill_level;
      endcase

      idle_cnt <= idle ? idle_cnt + IW'(1) : '0;

      if (rd_acc) begin
        rd_ptr         <= rd_ptr + AW'(1);
        data_out       <= pop_byte;
        data_out_valid <= 1'b1;
        if (pkt_rem == '0) begin
          pkt_done <= 1'b0;
          if (pop_hdr) begin
            pkt_rem <= hdr_rem(pop_byte);
          end else begin
            protocol_err <= 1'b1;
          end
        end else begin
          // Mid-packet the header flag is ignored; everything counts as payload.
          pkt_rem  <= pkt_rem - RW'(1);
          pkt_done <= (pkt_rem == RW'(1));
        end
      end else begin
        data_out_valid <= 1'b0;
        pkt_done       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_router_fifo_pkt.sv
module tb_router_fifo_pkt;

  logic       clk = 1'b0;
  logic       reset, soft_reset, write_enb, lfd_state, read_enb;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_out_valid, pkt_done, full, empty, almost_full;
  logic [4:0] fill_level;
  logic       timeout_flush, protocol_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] exp_q[$];  // {pkt_done, data}

  router_fifo_pkt #(.DATA_WIDTH(8), .DEPTH(16), .AFULL_LEVEL(14), .TIMEOUT(30)) dut (
    .clk(clk), .reset(reset), .soft_reset(soft_reset),
    .write_enb(write_enb), .lfd_state(lfd_state), .data_in(data_in),
    .read_enb(read_enb), .data_out(data_out), .data_out_valid(data_out_valid),
    .pkt_done(pkt_done), .full(full), .empty(empty), .almost_full(almost_full),
    .fill_level(fill_level), .timeout_flush(timeout_flush), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic hdr, input logic [7:0] d);
    write_enb = 1'b1; lfd_state = hdr; data_in = d;
    tick();
    write_enb = 1'b0; lfd_state = 1'b0;
  endtask

  task automatic rd_exp(input logic [7:0] d, input logic pd);
    exp_q.push_back({pd, d});
    read_enb = 1'b1;
    tick();
    read_enb = 1'b0;
  endtask

  // Monitor: compares every presented byte against the scoreboard
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (data_out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_output: got data 0x%0h, no byte expected at %0t", data_out, $time);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("data_out", {24'd0, data_out}, {24'd0, e[7:0]});
          check("pkt_done", {31'd0, pkt_done}, {31'd0, e[8]});
        end
      end else if (pkt_done !== 1'b0) begin
        check("pkt_done_without_valid", {31'd0, pkt_done}, 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; soft_reset = 1'b0; write_enb = 1'b0; lfd_state = 1'b0;
    read_enb = 1'b0; data_in = 8'h00;
    tick(); tick();
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_afull", {31'd0, almost_full}, 32'd0);
    check("rst_fill", {27'd0, fill_level}, 32'd0);
    check("rst_valid", {31'd0, data_out_valid}, 32'd0);
    check("rst_data", {24'd0, data_out}, 32'd0);
    check("rst_pkt_done", {31'd0, pkt_done}, 32'd0);
    check("rst_tflush", {31'd0, timeout_flush}, 32'd0);
    check("rst_perr", {31'd0, protocol_err}, 32'd0);
    reset = 1'b0;

    // Basic packet: header len=3, three payload bytes, parity
    wr(1'b1, 8'h0C); wr(1'b0, 8'h11); wr(1'b0, 8'h22); wr(1'b0, 8'h33); wr(1'b0, 8'h44);
    check("pkt_fill5", {27'd0, fill_level}, 32'd5);
    rd_exp(8'h0C, 1'b0);
    check("pkt_fill4", {27'd0, fill_level}, 32'd4);
    rd_exp(8'h11, 1'b0); rd_exp(8'h22, 1'b0); rd_exp(8'h33, 1'b0); rd_exp(8'h44, 1'b1);
    check("pkt_fill0", {27'd0, fill_level}, 32'd0);
    check("pkt_empty", {31'd0, empty}, 32'd1);
    tick();
    check("pkt_idle_valid", {31'd0, data_out_valid}, 32'd0);

    // Fill to full with one 16-byte packet (header len=14)
    wr(1'b1, 8'h38);
    for (int i = 1; i <= 14; i++) begin
      wr(1'b0, 8'(i));
      if (i == 12) check("afull_at13", {31'd0, almost_full}, 32'd0);
      if (i == 13) check("afull_at14", {31'd0, almost_full}, 32'd1);
      if (i == 13) check("notfull_at14", {31'd0, full}, 32'd0);
    end
    wr(1'b0, 8'hF0);
    check("full_16", {31'd0, full}, 32'd1);
    check("fill_16", {27'd0, fill_level}, 32'd16);
    wr(1'b0, 8'hAA);
    check("drop_17th", {27'd0, fill_level}, 32'd16);
    // Read+write while full: only the read is accepted
    exp_q.push_back({1'b0, 8'h38});
    write_enb = 1'b1; data_in = 8'hBB; read_enb = 1'b1;
    tick();
    write_enb = 1'b0; read_enb = 1'b0;
    check("rw_full_fill", {27'd0, fill_level}, 32'd15);
    for (int i = 1; i <= 14; i++) rd_exp(8'(i), 1'b0);
    rd_exp(8'hF0, 1'b1);
    check("drain_empty", {31'd0, empty}, 32'd1);

    // Empty FIFO: simultaneous read+write, no fall-through (header len=0)
    write_enb = 1'b1; lfd_state = 1'b1; data_in = 8'h00; read_enb = 1'b1;
    tick();
    write_enb = 1'b0; lfd_state = 1'b0; read_enb = 1'b0;
    check("rw_empty_fill", {27'd0, fill_level}, 32'd1);
    check("rw_empty_valid", {31'd0, data_out_valid}, 32'd0);
    rd_exp(8'h00, 1'b0);
    wr(1'b0, 8'h5A);
    rd_exp(8'h5A, 1'b1);
    check("len0_perr", {31'd0, protocol_err}, 32'd0);

    // Idle timeout: first write is not idle, writes 2 and 3 are idle 1 and 2
    wr(1'b1, 8'h04); wr(1'b0, 8'h61); wr(1'b0, 8'h62);
    for (int i = 3; i <= 29; i++) begin
      tick();
      if (timeout_flush !== 1'b0 || fill_level !== 5'd3)
        check("to_early", {26'd0, timeout_flush, fill_level}, {26'd0, 1'b0, 5'd3});
    end
    n_checks++;
    tick();
    check("to_pulse", {31'd0, timeout_flush}, 32'd1);
    check("to_fill", {27'd0, fill_level}, 32'd0);
    check("to_empty", {31'd0, empty}, 32'd1);
    tick();
    check("to_pulse_end", {31'd0, timeout_flush}, 32'd0);

    // Read on idle cycle 29 restarts the timer
    wr(1'b1, 8'h04); wr(1'b0, 8'h61); wr(1'b0, 8'h62);
    for (int i = 3; i <= 28; i++) tick();
    rd_exp(8'h04, 1'b0);
    check("to_rd_noflush", {31'd0, timeout_flush}, 32'd0);
    for (int i = 1; i <= 29; i++) begin
      tick();
      if (timeout_flush !== 1'b0)
        check("to_after_rd", {31'd0, timeout_flush}, 32'd0);
    end
    check("to_after_rd_fill", {27'd0, fill_level}, 32'd2);
    rd_exp(8'h61, 1'b0); rd_exp(8'h62, 1'b1);

    // Soft reset mid-packet, with a write presented at the same time
    wr(1'b1, 8'h0C); wr(1'b0, 8'h11); wr(1'b0, 8'h22); wr(1'b0, 8'h33); wr(1'b0, 8'h44);
    rd_exp(8'h0C, 1'b0); rd_exp(8'h11, 1'b0);
    soft_reset = 1'b1; write_enb = 1'b1; data_in = 8'hEE;
    tick();
    soft_reset = 1'b0; write_enb = 1'b0;
    check("srst_fill", {27'd0, fill_level}, 32'd0);
    check("srst_valid", {31'd0, data_out_valid}, 32'd0);
    check("srst_perr", {31'd0, protocol_err}, 32'd0);
    wr(1'b1, 8'h04); wr(1'b0, 8'h77); wr(1'b0, 8'h78);
    rd_exp(8'h04, 1'b0); rd_exp(8'h77, 1'b0); rd_exp(8'h78, 1'b1);
    check("srst_perr_after", {31'd0, protocol_err}, 32'd0);

    // Protocol error: payload byte with no open packet
    wr(1'b0, 8'h55);
    rd_exp(8'h55, 1'b0);
    check("perr_set", {31'd0, protocol_err}, 32'd1);
    tick();
    check("perr_sticky", {31'd0, protocol_err}, 32'd1);
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    check("perr_after_srst", {31'd0, protocol_err}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("perr_after_rst", {31'd0, protocol_err}, 32'd0);

    tick(); tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
